temporal_encoder: RTL and testbench

TEMPORAL_ENCODER -- requirements
Module: temporal_encoder

---
 rtl/temporal_encoder.sv | 163 ++++++++++++++++
 tb/tb_temporal_encoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/temporal_encoder.sv
// -----------------------------------------------------------------------------
// temporal_encoder
//   Converts a spike-time token into edge-coded and pulse-coded spikes inside a
//   fixed-length gamma cycle. One token is active (being emitted) while at most
//   one further token waits in a single-entry buffer, so consecutive gammas run
//   back to back without an idle cycle.
//
// Parameters
//   GAMMA_CYCLE_WIDTH : clock cycles per gamma cycle (>= 4)
//   PULSE_WIDTH       : pulse_out length in cycles (>= 1)
//   VAL_WIDTH         : in_value width (>= clog2(GAMMA_CYCLE_WIDTH))
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   in_valid  in   token offered
//   in_ready  out  token accepted this cycle (buffer empty and not in reset)
//   in_value  in   spike time v; edge appears at gamma count v+1
//   in_null   in   no-spike token
//   gamma_rst out  high in IDLE and at count 0 of every gamma
//   edge_out  out  high from count v+1 to gamma end
//   pulse_out out  high for PULSE_WIDTH cycles from count v+1, cut at gamma end
//   busy      out  a gamma cycle is running
// -----------------------------------------------------------------------------
module temporal_encoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int VAL_WIDTH         = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [VAL_WIDTH-1:0] in_value,
  input  logic                 in_null,
  output logic                 gamma_rst,
  output logic                 edge_out,
  output logic                 pulse_out,
  output logic                 busy
);

  localparam int CNT_W = (GAMMA_CYCLE_WIDTH > 1) ? $clog2(GAMMA_CYCLE_WIDTH) : 1;
  // Wide enough that v + 1 + PULSE_WIDTH can never wrap.
  localparam int CMP_W = VAL_WIDTH + $clog2(PULSE_WIDTH + 1) + 1;
  localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [VAL_WIDTH-1:0] V_NULL_MIN = VAL_WIDTH'(GAMMA_CYCLE_WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 act_null_q, act_null_d;
  logic [VAL_WIDTH-1:0] act_val_q, act_val_d;
  logic                 buf_full_q, buf_full_d;
  logic                 buf_null_q, buf_null_d;
  logic [VAL_WIDTH-1:0] buf_val_q, buf_val_d;

  logic                 accept_s;
  logic                 tok_null_s;
  logic                 run_s;
  logic                 live_s;
  logic [CMP_W-1:0]     cnt_ext_s;
  logic [CMP_W-1:0]     spike_s;
  logic [CMP_W-1:0]     pulse_end_s;

  // Ready depends only on reset and buffer occupancy, never on in_valid.
  assign in_ready   = ~rst & ~buf_full_q;
  assign accept_s   = in_valid & in_ready;
  // Values that could never produce an edge inside the gamma behave as null.
  assign tok_null_s = in_null | (in_value >= V_NULL_MIN);

  // Next-state logic for the gamma FSM, counter, active and buffer registers.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_null_d = act_null_q;
    act_val_d  = act_val_q;
    buf_full_d = buf_full_q;
    buf_null_d = buf_null_q;
    buf_val_d  = buf_val_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept_s) begin
          act_null_d = tok_null_s;
          act_val_d  = in_value;
          state_d    = S_RUN;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // Gamma end: hand over buffered token, a token arriving now, or stop.
          if (buf_full_q) begin
            act_null_d = buf_null_q;
            act_val_d  = buf_val_q;
            buf_full_d = 1'b0;
            state_d    = S_RUN;
          end else if (accept_s) begin
            act_null_d = tok_null_s;
            act_val_d  = in_value;
            state_d    = S_RUN;
          end else begin
            state_d    = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (accept_s) begin
            buf_full_d = 1'b1;
            buf_null_d = tok_null_s;
            buf_val_d  = in_value;
          end else begin
            buf_full_d = buf_full_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset that drops both tokens.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      act_null_q <= 1'b1;
      act_val_q  <= '0;
      buf_full_q <= 1'b0;
      buf_null_q <= 1'b1;
      buf_val_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_null_q <= act_null_d;
      act_val_q  <= act_val_d;
      buf_full_q <= buf_full_d;
      buf_null_q <= buf_null_d;
      buf_val_q  <= buf_val_d;
    end
  end

  // Output decode uses registered state only; the pulse is cut at gamma end
  // naturally because the counter never exceeds GAMMA_CYCLE_WIDTH-1.
  assign run_s       = (state_q == S_RUN);
  assign live_s      = run_s & ~act_null_q;
  assign cnt_ext_s   = CMP_W'(cnt_q);
  assign spike_s     = CMP_W'(act_val_q) + CMP_W'(1);
  assign pulse_end_s = spike_s + CMP_W'(PULSE_WIDTH);

  assign busy      = run_s;
  assign gamma_rst = ~run_s | (cnt_q == '0);
  assign edge_out  = live_s & (cnt_ext_s >= spike_s);
  assign pulse_out = live_s & (cnt_ext_s >= spike_s) & (cnt_ext_s < pulse_end_s);

endmodule

// File: tb/tb_temporal_encoder.sv
module tb_temporal_encoder;
  localparam int G  = 16;
  localparam int P  = 8;
  localparam int VW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_null = 1'b0;
  logic [VW-1:0] in_value = '0;
  logic          in_ready, gamma_rst, edge_out, pulse_out, busy;

  temporal_encoder #(.GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(P), .VAL_WIDTH(VW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_null(in_null), .gamma_rst(gamma_rst),
    .edge_out(edge_out), .pulse_out(pulse_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [G-1:0] e;
    logic [G-1:0] p;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   gammas = 0;

  // Expected per-count waveform of one gamma, straight from the encoding rules.
  function automatic exp_t model(input int v, input bit nul);
    exp_t x;
    bit silent;
    silent = nul || (v > G - 2);
    for (int k = 0; k < G; k++) begin
      x.e[k] = !silent && (k >= v + 1);
      x.p[k] = !silent && (k >= v + 1) && (k < v + 1 + P);
    end
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a token until accepted; report cycles waited and {busy,gamma_rst} at acceptance.
  task automatic send(input int v, input bit nul, output int waited, output logic [1:0] st_acc);
    bit ok;
    ok = 1'b0;
    waited = 0;
    st_acc = 2'b00;
    in_valid = 1'b1;
    in_value = VW'(v);
    in_null  = nul;
    for (int t = 0; t < 4 * G && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back(model(v, nul));
        st_acc = {busy, gamma_rst};
        ok = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_null  = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_timeout: token v=%0d never accepted after %0d cycles", v, waited);
    end
  endtask

  // Monitor: collect each gamma from its count-0 cycle and compare with the scoreboard.
  initial begin : monitor
    int idx;
    exp_t cur;
    bit collecting;
    logic [G-1:0] oe, op, og, ob;
    idx = 0;
    collecting = 1'b0;
    cur.e = '0;
    cur.p = '0;
    oe = '0; op = '0; og = '0; ob = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        collecting = 1'b0;
      end else begin
        if (busy && gamma_rst) begin
          if (collecting) chk("gamma_length", idx, G);
          total++;
          if (sbq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_gamma: got gamma start with empty scoreboard at %0t", $time);
            cur.e = '0;
            cur.p = '0;
          end else begin
            cur = sbq.pop_front();
          end
          collecting = 1'b1;
          idx = 0;
        end
        if (collecting) begin
          oe[idx] = edge_out;
          op[idx] = pulse_out;
          og[idx] = gamma_rst;
          ob[idx] = busy;
          idx++;
          if (idx == G) begin
            chk("edge_mask", 32'(oe), 32'(cur.e));
            chk("pulse_mask", 32'(op), 32'(cur.p));
            chk("gamma_rst_mask", 32'(og), 32'h1);
            chk("busy_mask", 32'(ob), 32'(G == 32 ? 32'hFFFF_FFFF : (32'h1 << G) - 32'h1));
            gammas++;
            collecting = 1'b0;
          end
        end else begin
          chk("idle_outputs", {28'h0, busy, gamma_rst, edge_out, pulse_out}, 32'h4);
        end
      end
    end
  end

  initial begin : stim
    int w;
    logic [1:0] st;
    int bc;
    int r, gap, v;
    bit nul;

    // Reset behaviour
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_state", {busy, gamma_rst, edge_out, pulse_out, in_ready}, 5'b01001);

    // Scenario 1: single token v=3 from IDLE
    step();
    send(3, 1'b0, w, st);
    @(negedge clk);
    chk("s1_start", {busy, gamma_rst}, 2'b11);
    repeat (16) step();
    @(negedge clk);
    chk("s1_end_idle", {busy, gamma_rst}, 2'b01);

    // Scenario 4: back-to-back tokens with a third held valid
    step();
    send(2, 1'b0, w, st);
    send(5, 1'b0, w, st);
    chk("s4_second_wait", w, 0);
    chk("s4_second_at_cnt0", st, 2'b11);
    send(7, 1'b0, w, st);
    chk("s4_third_wait", w, G - 1);
    chk("s4_no_gap", st, 2'b11);
    repeat (2 * G + 4) step();

    // Scenario 5: token presented only at count 15 of a running gamma
    send(3, 1'b0, w, st);
    repeat (G - 1) step();
    send(9, 1'b0, w, st);
    chk("s5_wait", w, 0);
    chk("s5_at_last", st, 2'b10);
    @(negedge clk);
    chk("s5_restart", {busy, gamma_rst}, 2'b11);
    repeat (2 * G + 4) step();

    // Scenarios 2/3: truncation, latest edge and null-like values
    send(10, 1'b0, w, st);
    send(14, 1'b0, w, st);
    send(15, 1'b0, w, st);
    send(20, 1'b0, w, st);
    send(6, 1'b1, w, st);
    repeat (2 * G + 4) step();

    // Scenario 6: reset at count 7 with a full buffer
    send(4, 1'b0, w, st);
    send(6, 1'b0, w, st);
    repeat (6) step();
    rst = 1'b1;
    @(negedge clk);
    chk("s6_rst_ready", in_ready, 0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("s6_after_rst", {busy, gamma_rst, edge_out, pulse_out, in_ready}, 5'b01001);
    bc = 0;
    repeat (3 * G) begin
      @(negedge clk);
      bc += int'(busy);
    end
    chk("s6_abandoned", bc, 0);

    // Randomized traffic with occasional resets
    step();
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 39);
      if (r == 0) begin
        rst = 1'b1;
        @(negedge clk);
        sbq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
      end else begin
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
        repeat (gap) step();
        v = $urandom_range(0, 31);
        nul = ($urandom_range(0, 7) == 0);
        send(v, nul, w, st);
      end
    end

    repeat (3 * G) step();
    chk("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
